// File: rtl/pswd_pkg.sv
// pswd_pkg: shared state encoding, BCD constants and counter widths for the password lock
package pswd_pkg;
  typedef enum logic [1:0] {
    WAITING  = 2'b00,
    EDITING  = 2'b01,
    UNLOCKED = 2'b10,
    ALARMING = 2'b11
  } state_e;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int ERR_W = 4;
endpackage

// File: rtl/pswd_idle_timer.sv
// pswd_idle_timer: idle cycle counter with terminal-count pulse
//   clk_i, reset_i : clock, async active-high reset
//   clr_i          : reload count to 0 (wins over en_i)
//   en_i           : advance count by one per cycle
//   max_i          : terminal value
//   tc_o           : high while enabled and count equals max_i
module pswd_idle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tc_o = en_i && (cnt_q == max_i);
endmodule

// File: rtl/pswd_lock_ctrl.sv
// pswd_lock_ctrl: BCD password lock with entry register, error lockout, idle timeouts and password change
//   clk_i, reset_i            : clock, async active-high reset
//   edit_req_i/load_i/del_i/ok_i/set_pswd_i/admin_clear_i : one-cycle strobes
//   digit_i                   : BCD digit to shift in
//   state_out_o               : 00 WAITING, 01 EDITING, 10 UNLOCKED, 11 ALARMING
//   entry_o/entry_len_o       : entered digits (newest in [3:0]) and their count
//   err_count_o               : consecutive wrong attempts
//   match_o/mismatch_o/reject_o : one-cycle result pulses
module pswd_lock_ctrl
  import pswd_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_ERRORS     = 3,
  parameter int unsigned EDIT_TIMEOUT   = 10_000_000,
  parameter int unsigned UNLOCK_TIMEOUT = 20_000_000,
  parameter logic [4*DIGITS-1:0] INIT_PSWD = 16'h1234,
  localparam int EW = BCD_W * DIGITS,
  localparam int LW = $clog2(DIGITS + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             edit_req_i,
  input  logic             load_i,
  input  logic             del_i,
  input  logic [BCD_W-1:0] digit_i,
  input  logic             ok_i,
  input  logic             set_pswd_i,
  input  logic             admin_clear_i,
  output logic [1:0]       state_out_o,
  output logic [EW-1:0]    entry_o,
  output logic [LW-1:0]    entry_len_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic             match_o,
  output logic             mismatch_o,
  output logic             reject_o
);
  localparam int unsigned TMAX = (EDIT_TIMEOUT > UNLOCK_TIMEOUT) ? EDIT_TIMEOUT : UNLOCK_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(MAX_ERRORS);
  localparam logic [LW-1:0] LEN_FULL = LW'(DIGITS);

  state_e           state_q, state_d;
  logic [EW-1:0]    entry_q, entry_d, pswd_q, pswd_d;
  logic [LW-1:0]    len_q, len_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic             match_q, match_d, mismatch_q, mismatch_d, reject_q, reject_d;
  logic             session, full, tmr_clr, tmr_tc;
  logic [TW-1:0]    tmr_max;

  assign session = (state_q == EDITING) || (state_q == UNLOCKED);
  assign full    = (len_q == LEN_FULL);
  assign err_inc = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
  assign tmr_max = (state_q == EDITING) ? TW'(EDIT_TIMEOUT - 1) : TW'(UNLOCK_TIMEOUT - 1);

  // Timer runs only inside a session; outside it is held cleared.
  pswd_idle_timer #(.W(TW)) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (tmr_clr || !session),
    .en_i    (session),
    .max_i   (tmr_max),
    .tc_o    (tmr_tc)
  );

  // Event chain is ordered by priority; only the first matching event acts.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    len_d      = len_q;
    err_d      = err_q;
    pswd_d     = pswd_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    reject_d   = 1'b0;
    tmr_clr    = 1'b0;
    if (admin_clear_i) begin
      err_d = '0;
      if (state_q == ALARMING) state_d = WAITING;
    end else if (tmr_tc) begin
      state_d = WAITING;
      entry_d = '0;
      len_d   = '0;
    end else if (state_q == WAITING) begin
      if (edit_req_i) begin
        state_d = EDITING;
        entry_d = '0;
        len_d   = '0;
      end
    end else if (session && ok_i) begin
      entry_d = '0;
      len_d   = '0;
      if (state_q == UNLOCKED) begin
        state_d = WAITING;
      end else if (full && entry_q == pswd_q) begin
        match_d = 1'b1;
        err_d   = '0;
        state_d = UNLOCKED;
        tmr_clr = 1'b1;
      end else begin
        mismatch_d = 1'b1;
        err_d      = err_inc;
        if (err_inc == ERR_MAX) state_d = ALARMING;
      end
    end else if (state_q == UNLOCKED && set_pswd_i) begin
      if (full) begin
        pswd_d  = entry_q;
        entry_d = '0;
        len_d   = '0;
        tmr_clr = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end else if (session && del_i) begin
      if (len_q != '0) begin
        entry_d = entry_q >> BCD_W;
        len_d   = len_q - 1'b1;
        tmr_clr = 1'b1;
      end
    end else if (session && load_i) begin
      if (digit_i > BCD_MAX || full) begin
        reject_d = 1'b1;
      end else begin
        entry_d = EW'({entry_q, digit_i});
        len_d   = len_q + 1'b1;
        tmr_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= WAITING;
      entry_q    <= '0;
      len_q      <= '0;
      err_q      <= '0;
      pswd_q     <= INIT_PSWD;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      len_q      <= len_d;
      err_q      <= err_d;
      pswd_q     <= pswd_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      reject_q   <= reject_d;
    end
  end

  assign state_out_o = state_q;
  assign entry_o     = entry_q;
  assign entry_len_o = len_q;
  assign err_count_o = err_q;
  assign match_o     = match_q;
  assign mismatch_o  = mismatch_q;
  assign reject_o    = reject_q;
endmodule

// File: tb/tb_pswd_lock_ctrl.sv
// tb_pswd_lock_ctrl: directed scoreboard bench for pswd_lock_ctrl
module tb_pswd_lock_ctrl;
  localparam logic [5:0] NO = 6'b000000, ED = 6'b100000, LD = 6'b010000, DL = 6'b001000;
  localparam logic [5:0] OK = 6'b000100, SP = 6'b000010, AC = 6'b000001;
  localparam logic [1:0] SW = 2'd0, SE = 2'd1, SU = 2'd2, SA = 2'd3;
  localparam logic [2:0] P0 = 3'b000, PM = 3'b100, PX = 3'b010, PR = 3'b001;

  logic clk = 1'b0, reset = 1'b1;
  logic edit_req = 1'b0, load = 1'b0, del = 1'b0, ok = 1'b0, set_pswd = 1'b0, admin_clear = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [1:0] state_out;
  logic [15:0] entry;
  logic [2:0] entry_len;
  logic [3:0] err_count;
  logic match, mismatch, reject;
  logic [27:0] obs;
  int checks = 0, failures = 0;

  typedef struct {
    string       tag;
    logic [27:0] v;
  } exp_t;
  exp_t sb[$];

  pswd_lock_ctrl #(
    .DIGITS(4), .MAX_ERRORS(3), .EDIT_TIMEOUT(16), .UNLOCK_TIMEOUT(40), .INIT_PSWD(16'h1234)
  ) dut (
    .clk_i(clk), .reset_i(reset), .edit_req_i(edit_req), .load_i(load), .del_i(del),
    .digit_i(digit), .ok_i(ok), .set_pswd_i(set_pswd), .admin_clear_i(admin_clear),
    .state_out_o(state_out), .entry_o(entry), .entry_len_o(entry_len), .err_count_o(err_count),
    .match_o(match), .mismatch_o(mismatch), .reject_o(reject)
  );

  always #5 clk = ~clk;
  assign obs = {state_out, entry, entry_len, err_count, match, mismatch, reject};

  function automatic logic [27:0] pk(input logic [1:0] st, input logic [15:0] en, input logic [2:0] len,
                                     input logic [3:0] err, input logic [2:0] pl);
    return {st, en, len, err, pl};
  endfunction

  task automatic check_out();
    exp_t x;
    x = sb.pop_front();
    checks++;
    assert (obs === x.v) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", x.tag, obs, x.v);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] s, input logic [3:0] dg, input logic [27:0] e);
    exp_t x;
    @(negedge clk);
    {edit_req, load, del, ok, set_pswd, admin_clear} = s;
    digit = dg;
    x.tag = tag;
    x.v = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    {edit_req, load, del, ok, set_pswd, admin_clear} = NO;
    check_out();
  endtask

  task automatic idle(input string tag, input int n, input logic [27:0] e);
    repeat (n) step(tag, NO, 4'd0, e);
  endtask

  task automatic load_seq(input string tag, input logic [15:0] v, input logic [1:0] st, input logic [3:0] err);
    for (int i = 0; i < 4; i++)
      step(tag, LD, v[15-4*i -: 4], pk(st, v >> (4 * (3 - i)), 3'(i + 1), err, P0));
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (obs === 28'h0) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, 28'h0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    step("after_reset", NO, 4'd0, pk(SW, 16'h0, 3'd0, 4'd0, P0));
    step("wait_load_ignored", LD, 4'd3, pk(SW, 16'h0, 3'd0, 4'd0, P0));
    step("edit", ED, 4'd0, pk(SE, 16'h0, 3'd0, 4'd0, P0));
    load_seq("ld_1234", 16'h1234, SE, 4'd0);
    step("ok_match", OK, 4'd0, pk(SU, 16'h0, 3'd0, 4'd0, PM));
    load_seq("ld_4321", 16'h4321, SU, 4'd0);
    step("set_pswd", SP, 4'd0, pk(SU, 16'h0, 3'd0, 4'd0, P0));
    step("unl_ld5", LD, 4'd5, pk(SU, 16'h5, 3'd1, 4'd0, P0));
    step("set_short", SP, 4'd0, pk(SU, 16'h5, 3'd1, 4'd0, PR));
    step("relock", OK, 4'd0, pk(SW, 16'h0, 3'd0, 4'd0, P0));
    step("edit2", ED, 4'd0, pk(SE, 16'h0, 3'd0, 4'd0, P0));
    load_seq("old_pw", 16'h1234, SE, 4'd0);
    step("old_pw_ok", OK, 4'd0, pk(SE, 16'h0, 3'd0, 4'd1, PX));
    load_seq("new_pw", 16'h4321, SE, 4'd1);
    step("new_pw_ok", OK, 4'd0, pk(SU, 16'h0, 3'd0, 4'd0, PM));
    step("relock2", OK, 4'd0, pk(SW, 16'h0, 3'd0, 4'd0, P0));
    step("edit3", ED, 4'd0, pk(SE, 16'h0, 3'd0, 4'd0, P0));
    for (int k = 1; k <= 3; k++) begin
      load_seq("bad_pw", 16'h1239, SE, 4'(k - 1));
      step("bad_ok", OK, 4'd0, pk((k == 3) ? SA : SE, 16'h0, 3'd0, 4'(k), PX));
    end
    step("alarm_load", LD, 4'd1, pk(SA, 16'h0, 3'd0, 4'd3, P0));
    step("alarm_ok", OK, 4'd0, pk(SA, 16'h0, 3'd0, 4'd3, P0));
    step("alarm_edit", ED, 4'd0, pk(SA, 16'h0, 3'd0, 4'd3, P0));
    step("admin_clear", AC, 4'd0, pk(SW, 16'h0, 3'd0, 4'd0, P0));
    step("edit4", ED, 4'd0, pk(SE, 16'h0, 3'd0, 4'd0, P0));
    step("ld5", LD, 4'd5, pk(SE, 16'h5, 3'd1, 4'd0, P0));
    step("ld11_rej", LD, 4'd11, pk(SE, 16'h5, 3'd1, 4'd0, PR));
    step("ld6", LD, 4'd6, pk(SE, 16'h56, 3'd2, 4'd0, P0));
    step("ld7", LD, 4'd7, pk(SE, 16'h567, 3'd3, 4'd0, P0));
    step("ld8", LD, 4'd8, pk(SE, 16'h5678, 3'd4, 4'd0, P0));
    step("ld9_full", LD, 4'd9, pk(SE, 16'h5678, 3'd4, 4'd0, PR));
    step("del1", DL, 4'd0, pk(SE, 16'h567, 3'd3, 4'd0, P0));
    step("del2", DL, 4'd0, pk(SE, 16'h56, 3'd2, 4'd0, P0));
    step("del3", DL, 4'd0, pk(SE, 16'h5, 3'd1, 4'd0, P0));
    step("del4", DL, 4'd0, pk(SE, 16'h0, 3'd0, 4'd0, P0));
    step("del_empty", DL, 4'd0, pk(SE, 16'h0, 3'd0, 4'd0, P0));
    step("ok_short", OK, 4'd0, pk(SE, 16'h0, 3'd0, 4'd1, PX));
    step("to_ld7", LD, 4'd7, pk(SE, 16'h7, 3'd1, 4'd1, P0));
    idle("edit_idle", 15, pk(SE, 16'h7, 3'd1, 4'd1, P0));
    step("edit_timeout", NO, 4'd0, pk(SW, 16'h0, 3'd0, 4'd1, P0));
    step("admin_wait", AC, 4'd0, pk(SW, 16'h0, 3'd0, 4'd0, P0));
    step("edit5", ED, 4'd0, pk(SE, 16'h0, 3'd0, 4'd0, P0));
    step("keep_ld1", LD, 4'd1, pk(SE, 16'h1, 3'd1, 4'd0, P0));
    idle("keep_idle1", 9, pk(SE, 16'h1, 3'd1, 4'd0, P0));
    step("keep_ld2", LD, 4'd2, pk(SE, 16'h12, 3'd2, 4'd0, P0));
    idle("keep_idle2", 9, pk(SE, 16'h12, 3'd2, 4'd0, P0));
    step("keep_ld3", LD, 4'd3, pk(SE, 16'h123, 3'd3, 4'd0, P0));
    idle("keep_idle3", 9, pk(SE, 16'h123, 3'd3, 4'd0, P0));
    step("keep_del", DL, 4'd0, pk(SE, 16'h12, 3'd2, 4'd0, P0));
    idle("keep_idle4", 9, pk(SE, 16'h12, 3'd2, 4'd0, P0));
    step("keep_ok", OK, 4'd0, pk(SE, 16'h0, 3'd0, 4'd1, PX));
    load_seq("pw4321", 16'h4321, SE, 4'd1);
    step("pw4321_ok", OK, 4'd0, pk(SU, 16'h0, 3'd0, 4'd0, PM));
    load_seq("ld_5555", 16'h5555, SU, 4'd0);
    step("set_5555", SP, 4'd0, pk(SU, 16'h0, 3'd0, 4'd0, P0));
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset("async_reset");
    @(negedge clk);
    reset = 1'b0;
    step("edit6", ED, 4'd0, pk(SE, 16'h0, 3'd0, 4'd0, P0));
    load_seq("init_pw", 16'h1234, SE, 4'd0);
    step("init_pw_ok", OK, 4'd0, pk(SU, 16'h0, 3'd0, 4'd0, PM));
    idle("unl_idle", 39, pk(SU, 16'h0, 3'd0, 4'd0, P0));
    step("unl_timeout", NO, 4'd0, pk(SW, 16'h0, 3'd0, 4'd0, P0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
